// File: rtl/wb_line_master_if.sv
// wb_line_master_if: bundles the line request/response port and the Wishbone
// initiator signals of wb_line_master.
//   req_*  : line request from the refill/writeback engine (valid/ready)
//   rsp_*  : completion back to the engine (valid/ready, data, timeout error)
//   busy_o : initiator not idle
//   wb_*   : classic Wishbone initiator towards the DRAM responder
// Modports: master = the wb_line_master view, slave = the surrounding system.
interface wb_line_master_if #(
  parameter int unsigned WORD_SIZE = 256
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [31:0]          req_addr_i;
  logic [WORD_SIZE-1:0] req_data_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [WORD_SIZE-1:0] rsp_data_o;
  logic                 rsp_err_o;

  logic                 busy_o;

  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic [31:0]          wb_addr_o;
  logic [WORD_SIZE-1:0] wb_data_o;
  logic [WORD_SIZE-1:0] wb_data_i;
  logic                 wb_ack_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i, wb_data_i, wb_ack_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_data_i, rsp_ready_i, wb_data_i, wb_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/wb_line_master.sv
// wb_line_master: moves one WORD_SIZE-bit line per classic Wishbone cycle between
// a local request/response port and the DRAM responder.
// Ports:
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   bus     : wb_line_master_if.master (request, response, busy and Wishbone signals)
// Every output except req_ready_o and busy_o is a register. The responder holds
// ack high until it sees stb/cyc drop, so acceptance is gated on ack being low;
// ack is otherwise only acted upon in the BUS state.
module wb_line_master #(
  parameter int unsigned WORD_SIZE      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic              clk_i,
  input logic              rst_n_i,
  wb_line_master_if.master bus
);

  localparam int unsigned CntW      = ($clog2(TIMEOUT_CYCLES + 1) > 0) ?
                                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [31:0]     LineMask = 32'(WORD_SIZE / 8 - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [31:0]          addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic accept;
  logic timeout_hit;

  // A stale, still-held ack from the previous cycle blocks a new accept.
  assign accept      = (state_q == StIdle) && bus.req_valid_i && !bus.wb_ack_i;
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StBus;
      StBus:  if (bus.wb_ack_i || timeout_hit) state_d = StResp;
      StResp: if (bus.rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = bus.req_we_i;
          addr_d  = bus.req_addr_i & ~LineMask;
          wdata_d = bus.req_data_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      StBus: begin
        // Saturate so the counter cannot wrap when the timeout is disabled.
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus.wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_data_d  = we_q ? '0 : bus.wb_data_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (timeout_hit) begin
          cyc_d       = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready_i) rsp_valid_d = 1'b0;
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready_o = accept || ((state_q == StIdle) && !bus.wb_ack_i);
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = wdata_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;

`ifndef SYNTHESIS
  // A pending response must not change until it is consumed.
  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (rsp_valid_q && !bus.rsp_ready_i) |=>
      (rsp_valid_q && $stable(rsp_data_q) && $stable(rsp_err_q)));
  // The bus cycle is only ever open while in BUS.
  a_cyc_in_bus: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    cyc_q |-> (state_q == StBus));
`endif

endmodule
